wallace_pipe_mult: RTL and testbench



---
 rtl/wallace_pipe_mult.sv | 152 +++++++++++++++
 tb/tb_wallace_pipe_mult.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wallace_pipe_mult.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiplier. The operands are registered, then the
// partial products pass through a carry-save Wallace tree and a prefix (CLA) adder, spread over STAGES.
module wallace_pipe_mult #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [2:0]           inflight
);
  localparam int PW   = 2*WIDTH;
  localparam int MAXR = WIDTH + 1;
  typedef logic [MAXR-1:0][PW-1:0] rows_t;

  function automatic int next_rows(input int n);
    return (n > 2) ? 2*(n/3) + n%3 : n;
  endfunction

  function automatic int num_layers(input int n0);
    int n, l;
    n = n0; l = 0;
    for (int i = 0; i < 64; i++)
      if (n > 2) begin n = next_rows(n); l++; end
    return l;
  endfunction

  localparam int NL = num_layers(MAXR);

  function automatic int cut(input int j);
    return j*NL/STAGES;
  endfunction

  // The top row of a signed multiplier is negated: ~row here, with the +1 carried in row WIDTH.
  function automatic rows_t pp_gen(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sg);
    rows_t r;
    logic [PW-1:0] ax;
    r  = '0;
    ax = {{WIDTH{sg & a[WIDTH-1]}}, a};
    for (int i = 0; i < WIDTH; i++)
      if (b[i]) r[i] = ax << i;
    if (sg & b[WIDTH-1]) begin
      r[WIDTH-1] = ~(ax << (WIDTH-1));
      r[WIDTH]   = PW'(1);
    end
    return r;
  endfunction

  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o;
    o = '0;
    for (int g = 0; g < MAXR/3; g++)
      if (g < n/3) begin
        o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
      end
    for (int k = 0; k < 2; k++)
      if (k < n%3) o[2*(n/3)+k] = r[3*(n/3)+k];
    return o;
  endfunction

  function automatic rows_t reduce(input rows_t r, input int lo, input int hi);
    rows_t x;
    int n;
    x = r; n = MAXR;
    for (int l = 0; l < NL; l++) begin
      if (l >= lo && l < hi) x = csa_layer(x, n);
      n = next_rows(n);
    end
    return x;
  endfunction

  // Kogge-Stone prefix carries over the last two carry-save rows.
  function automatic logic [PW-1:0] cla_rows(input rows_t r);
    logic [PW-1:0] g, p, gg, pg;
    g = r[0] & r[1]; p = r[0] ^ r[1];
    gg = g; pg = p;
    for (int d = 1; d < PW; d = d*2)
      for (int i = PW-1; i >= d; i--) begin
        gg[i] = gg[i] | (pg[i] & gg[i-d]);
        pg[i] = pg[i] & pg[i-d];
      end
    return p ^ {gg[PW-2:0], 1'b0};
  endfunction

  logic              adv, acc, ret;
  logic [STAGES:1]   vld_pipe;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              s_q;
  rows_t             seg_in  [STAGES];
  rows_t             seg_out [STAGES];

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && rst_n;
  assign acc       = in_valid && in_ready;
  assign ret       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Data registers only load on a valid entry, so out_p keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; s_q <= 1'b0;
    end else if (acc) begin
      a_q <= in_a; b_q <= in_b; s_q <= in_signed;
    end
  end

  assign seg_in[0] = pp_gen(a_q, b_q, s_q);

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    assign seg_out[j] = reduce(seg_in[j], cut(j), cut(j+1));
  end

  for (genvar j = 1; j < STAGES; j++) begin : g_stg
    rows_t rows_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   rows_q <= '0;
      else if (adv && vld_pipe[j])  rows_q <= seg_out[j-1];
    end
    assign seg_in[j] = rows_q;
  end

  assign out_p = cla_rows(seg_out[STAGES-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else begin
      case ({acc, ret})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_wallace_pipe_mult.sv
// Bench for wallace_pipe_mult: an 8x8/3-stage and a 16x16/1-stage instance, checked against
// an arithmetic reference with an in-order queue of expected results.
module tb_wallace_pipe_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;  // 0: 8-bit/3-stage instance, 1: 16-bit/1-stage instance
  logic        in_valid, in_signed, out_ready;
  logic [15:0] in_a, in_b;
  logic        rdy8, ov8, rdy16, ov16;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [2:0]  inf8, inf16;
  logic        v8, v16;

  assign v8  = in_valid && !sel;
  assign v16 = in_valid && sel;

  wallace_pipe_mult #(.WIDTH(8), .STAGES(3)) u_m8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_signed(in_signed), .out_valid(ov8), .out_ready(out_ready), .out_p(p8), .inflight(inf8));

  wallace_pipe_mult #(.WIDTH(16), .STAGES(1)) u_m16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov16), .out_ready(out_ready), .out_p(p16), .inflight(inf16));

  logic        o_rdy, o_vld;
  logic [31:0] o_p;
  logic [2:0]  o_inf;
  assign o_rdy = sel ? rdy16 : rdy8;
  assign o_vld = sel ? ov16  : ov8;
  assign o_p   = sel ? p16   : {16'h0, p8};
  assign o_inf = sel ? inf16 : inf8;

  typedef struct { logic [15:0] a; logic [15:0] b; logic s; logic [31:0] p; } vec_t;
  typedef struct { logic [31:0] p; int age; } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int w);
    longint sa, sb, m;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    return 32'((sa * sb) & ((longint'(1) << (2*w)) - 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. A result reaches the output once its
  // age (advancing cycles spent in the pipe) equals the stage count; stalls freeze all ages.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [31:0] p, input logic r);
    int   stg;
    logic ev, adv, acc, ret;
    stg = sel ? 1 : 3;
    in_valid = v; in_a = a; in_b = b; in_signed = s; out_ready = r;
    #1;
    ev  = (q.size() > 0) && (q[0].age >= stg);
    adv = !ev || r;
    chk("out_valid", 32'(o_vld), 32'(ev));
    chk("in_ready",  32'(o_rdy), 32'(adv));
    chk("inflight",  32'(o_inf), 32'(q.size()));
    if (ev) chk("out_p", o_p, q[0].p);
    acc = v && adv;
    ret = ev && r;
    @(posedge clk);
    if (adv) begin
      if (ret) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) begin q.push_back('{p, 1}); n_acc++; end
    end
    @(negedge clk);
  endtask

  task automatic rnd_step(input int pv, input int pr);
    logic [15:0] a, b;
    logic s, v, r;
    a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
    v = ($urandom_range(0, 99) < pv);
    r = ($urandom_range(0, 99) < pr);
    step(v, a, b, s, ref_mul(a, b, s, sel ? 16 : 8), r);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b1);
    chk("drain_inflight", 32'(o_inf), 32'(0));
  endtask

  vec_t t8[6];
  vec_t t16[3];

  initial begin
    t8[0] = '{16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01};
    t8[1] = '{16'h0080, 16'h0080, 1'b1, 32'h00004000};
    t8[2] = '{16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF};
    t8[3] = '{16'h00FF, 16'h0001, 1'b0, 32'h000000FF};
    t8[4] = '{16'h007F, 16'h0081, 1'b1, 32'h0000C0FF};  // 127 * -127
    t8[5] = '{16'h0080, 16'h007F, 1'b1, 32'h0000C080};  // -128 * 127
    t16[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    t16[1] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
    t16[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};

    sel = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(o_vld), 32'(0));
    chk("rst_inflight",  32'(o_inf), 32'(0));
    chk("rst_in_ready",  32'(o_rdy), 32'(0));
    chk("rst_out_p",     o_p,        32'(0));
    rst_n = 1'b1;

    // single op, then idle long enough to see the latency and the retire
    step(1'b1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 1'b1);
    repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b1);

    // table vectors back to back
    for (int i = 0; i < 6; i++) step(1'b1, t8[i].a, t8[i].b, t8[i].s, t8[i].p, 1'b1);
    drain();

    // fill with three, stall five cycles with the producer holding a fourth, then release
    for (int i = 1; i <= 3; i++)
      step(1'b1, 16'(i+10), 16'(i+20), 1'b0, 32'((i+10)*(i+20)), 1'b0);
    repeat (5) step(1'b1, 16'h0009, 16'h0009, 1'b0, 32'd81, 1'b0);
    chk("stall_inflight", 32'(o_inf), 32'(3));
    chk("stall_in_ready", 32'(o_rdy), 32'(0));
    chk("stall_out_p",    o_p,        32'(11*21));
    step(1'b1, 16'h0009, 16'h0009, 1'b0, 32'd81, 1'b1);
    drain();

    // steady streaming, then random bubbles and backpressure
    repeat (20) rnd_step(100, 100);
    repeat (300) rnd_step(60, 70);
    drain();

    // reset between edges with two ops in flight, head held at the output
    step(1'b1, 16'h0011, 16'h0022, 1'b0, 32'h00000242, 1'b0);
    step(1'b1, 16'h0033, 16'h0044, 1'b0, 32'h00000D8C, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_out_valid", 32'(o_vld), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(o_vld), 32'(0));
    chk("mid_rst_inflight",  32'(o_inf), 32'(0));
    chk("mid_rst_in_ready",  32'(o_rdy), 32'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 1'b1);
    repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b1);
    drain();

    // 16-bit, single-stage instance
    sel = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, t16[i].a, t16[i].b, t16[i].s, t16[i].p, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0, 1'b1);
    n_acc = 0;
    for (int c = 0; c < 30000 && n_acc < 10000; c++) rnd_step(90, 80);
    chk("random_accepts", 32'(n_acc >= 10000), 32'(1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
